// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a valid/ready instruction-memory port and the IF/ID register.
// It has a one-entry hold buffer for stalls and a DISCARD state that drops the word still in flight after a redirect.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rd_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump_taken,
  input  logic [31:0] jump_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_insn,
  output logic        if_en,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a fetch completes on a rising edge where imem_req=1 and imem_rdy=1.
  // imem_addr stays stable while imem_req=1 and imem_rdy=0.
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_discard_addr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_insn;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic [31:0] r_if_insn;
  logic        r_if_en;

  logic [31:0] w_jump_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_buf_pc_plus4;
  logic [31:0] w_reset_pc;

  assign w_jump_pc      = {jump_addr[31:2], 2'b00};
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_buf_pc_plus4 = r_buf_pc + 32'd4;
  assign w_reset_pc     = {RESET_VECTOR[31:2], 2'b00};

  assign imem_req    = (r_state != S_HOLD);
  assign imem_addr   = (r_state == S_DISCARD) ? r_discard_addr : r_pc;
  assign busy        = imem_req & ~imem_rdy;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_insn     = r_if_insn;
  assign if_en       = r_if_en;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_pc           <= w_reset_pc;
      r_discard_addr <= 32'h0;
      r_buf_pc       <= 32'h0;
      r_buf_insn     <= 32'h0;
      r_if_pc        <= 32'h0;
      r_if_pc_plus4  <= 32'h0;
      r_if_insn      <= 32'h0;
      r_if_en        <= 1'b0;
    end else if (jump_taken) begin
      // Leaving HOLD empties the buffer; an unanswered request must be drained first.
      r_pc    <= w_jump_pc;
      r_if_en <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_discard_addr <= r_pc;
          r_state        <= imem_rdy ? S_FETCH : S_DISCARD;
        end
        S_DISCARD: r_state <= imem_rdy ? S_FETCH : S_DISCARD;
        default:   r_state <= S_FETCH;
      endcase
    end else begin
      if (flush) begin
        r_if_en   <= 1'b0;
        r_if_insn <= 32'h0;
      end
      case (r_state)
        S_FETCH: begin
          if (!flush) begin
            if (stall) begin
              if (imem_rdy) begin
                r_buf_pc   <= r_pc;
                r_buf_insn <= imem_rd_data;
                r_pc       <= w_pc_plus4;
                r_state    <= S_HOLD;
              end
            end else if (imem_rdy) begin
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_plus4;
              r_if_insn     <= imem_rd_data;
              r_if_en       <= 1'b1;
              r_pc          <= w_pc_plus4;
            end else begin
              r_if_en <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!flush && !stall) begin
            r_if_pc       <= r_buf_pc;
            r_if_pc_plus4 <= w_buf_pc_plus4;
            r_if_insn     <= r_buf_insn;
            r_if_en       <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        default: begin
          if (imem_rdy) r_state <= S_FETCH;
          if (!flush && !stall) r_if_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed vector table, hand-written corner sequences,
// and a random run compared against a queue-based reference model.
module tb_if_stage;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rd_data;
  logic        stall;
  logic        flush;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_insn;
  logic        if_en;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rd_data(imem_rd_data), .stall(stall), .flush(flush),
    .jump_taken(jump_taken), .jump_addr(jump_addr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_insn(if_insn), .if_en(if_en), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not finish (got no end, required end)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic j, input logic [31:0] ja,
                       input logic r, input logic [31:0] d);
    stall = s; flush = f; jump_taken = j; jump_addr = ja; imem_rdy = r; imem_rd_data = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, flush, jump;
    logic [31:0] jaddr;
    logic        rdy;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_en;
    logic [31:0] e_pc;
    logic [31:0] e_insn;
  } vec_t;

  function automatic vec_t mk(logic s, logic f, logic j, logic [31:0] ja, logic r, logic [31:0] d,
                              logic rq, logic [31:0] a, logic b, logic en, logic [31:0] p, logic [31:0] ins);
    vec_t v;
    v.stall = s; v.flush = f; v.jump = j; v.jaddr = ja; v.rdy = r; v.data = d;
    v.e_req = rq; v.e_addr = a; v.e_busy = b; v.e_en = en; v.e_pc = p; v.e_insn = ins;
    return v;
  endfunction

  vec_t tbl[18];

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  ent_t        m_buf[$];
  logic [31:0] m_pc, m_daddr, m_out_pc, m_out_insn;
  logic        m_disc, m_en, m_insn_known;

  task automatic model_reset();
    m_pc = 32'h0; m_daddr = 32'h0; m_disc = 1'b0; m_buf.delete();
    m_en = 1'b0; m_out_pc = 32'h0; m_out_insn = 32'h0; m_insn_known = 1'b1;
  endtask

  function automatic logic model_req();
    return m_disc || (m_buf.size() == 0);
  endfunction

  task automatic model_step();
    logic req;
    ent_t e;
    req = model_req();
    if (jump_taken) begin
      if (m_disc) begin
        if (imem_rdy) m_disc = 1'b0;
      end else if (req && !imem_rdy) begin
        m_disc = 1'b1; m_daddr = m_pc;
      end
      m_pc = jump_addr & ~32'h3; m_buf.delete(); m_en = 1'b0; m_insn_known = 1'b0;
    end else if (m_disc) begin
      if (imem_rdy) m_disc = 1'b0;
      if (flush) begin m_en = 1'b0; m_out_insn = 32'h0; m_insn_known = 1'b1; end
      else if (!stall) begin m_en = 1'b0; m_insn_known = 1'b0; end
    end else if (flush) begin
      m_en = 1'b0; m_out_insn = 32'h0; m_insn_known = 1'b1;
    end else if (stall) begin
      if (req && imem_rdy) begin
        e.pc = m_pc; e.insn = imem_rd_data; m_buf.push_back(e); m_pc = m_pc + 32'd4;
      end
    end else if (m_buf.size() > 0) begin
      e = m_buf.pop_front();
      m_out_pc = e.pc; m_out_insn = e.insn; m_en = 1'b1; m_insn_known = 1'b1;
    end else if (imem_rdy) begin
      m_out_pc = m_pc; m_out_insn = imem_rd_data; m_en = 1'b1; m_insn_known = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_en = 1'b0; m_insn_known = 1'b0;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;

    tbl[0]  = mk(0,0,0,32'h0,  1,32'hA000_0000, 1,32'h00,0, 1,32'h00,32'hA000_0000);
    tbl[1]  = mk(0,0,0,32'h0,  1,32'hA000_0001, 1,32'h04,0, 1,32'h04,32'hA000_0001);
    tbl[2]  = mk(0,0,0,32'h0,  1,32'hA000_0002, 1,32'h08,0, 1,32'h08,32'hA000_0002);
    tbl[3]  = mk(0,0,0,32'h0,  1,32'hA000_0003, 1,32'h0C,0, 1,32'h0C,32'hA000_0003);
    tbl[4]  = mk(0,0,0,32'h0,  0,32'hBAD0_0000, 1,32'h10,1, 0,32'h0, 32'h0);
    tbl[5]  = mk(0,0,0,32'h0,  0,32'hBAD0_0001, 1,32'h10,1, 0,32'h0, 32'h0);
    tbl[6]  = mk(0,0,0,32'h0,  0,32'hBAD0_0002, 1,32'h10,1, 0,32'h0, 32'h0);
    tbl[7]  = mk(0,0,0,32'h0,  1,32'hA000_0004, 1,32'h10,0, 1,32'h10,32'hA000_0004);
    tbl[8]  = mk(1,0,0,32'h0,  1,32'hA000_0005, 1,32'h14,0, 1,32'h10,32'hA000_0004);
    tbl[9]  = mk(1,0,0,32'h0,  1,32'hBAD0_0003, 0,32'h0, 0, 1,32'h10,32'hA000_0004);
    tbl[10] = mk(0,0,0,32'h0,  1,32'hBAD0_0004, 0,32'h0, 0, 1,32'h14,32'hA000_0005);
    tbl[11] = mk(0,0,0,32'h0,  1,32'hA000_0006, 1,32'h18,0, 1,32'h18,32'hA000_0006);
    tbl[12] = mk(0,0,1,32'h103,0,32'hBAD0_0005, 1,32'h1C,1, 0,32'h0, 32'h0);
    tbl[13] = mk(0,0,0,32'h0,  0,32'hBAD0_0006, 1,32'h1C,1, 0,32'h0, 32'h0);
    tbl[14] = mk(0,0,0,32'h0,  1,32'hDEAD_DEAD, 1,32'h1C,0, 0,32'h0, 32'h0);
    tbl[15] = mk(0,0,0,32'h0,  1,32'hA000_0007, 1,32'h100,0,1,32'h100,32'hA000_0007);
    tbl[16] = mk(0,1,0,32'h0,  1,32'hA000_0008, 1,32'h104,0,0,32'h0, 32'h0);
    tbl[17] = mk(0,0,0,32'h0,  1,32'hA000_0009, 1,32'h104,0,1,32'h104,32'hA000_0009);

    // reset state
    @(posedge clk); #1;
    chk("rst_if_en", {31'h0, if_en}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst_if_insn", if_insn, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].jump, tbl[i].jaddr, tbl[i].rdy, tbl[i].data);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].e_busy});
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i), {31'h0, if_en}, {31'h0, tbl[i].e_en});
      if (tbl[i].e_en) begin
        chk($sformatf("v%0d_pc", i), if_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_pc4", i), if_pc_plus4, tbl[i].e_pc + 32'd4);
        chk($sformatf("v%0d_insn", i), if_insn, tbl[i].e_insn);
      end
      if (tbl[i].flush) chk($sformatf("v%0d_flush_insn", i), if_insn, 32'h0);
      @(negedge clk);
    end

    // pc wrap: jump to the last word (low bits ignored), fetch it, next address is 0
    drive(0, 0, 1, 32'hFFFF_FFFE, 1, 32'h5555_5555);
    @(posedge clk); #1;
    chk("wrap_jump_en", {31'h0, if_en}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1, 32'hCAFE_0001);
    #1 chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("wrap_if_insn", if_insn, 32'hCAFE_0001);
    @(negedge clk);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // reset with the hold buffer full clears outputs without a clock edge
    drive(1, 0, 0, 32'h0, 1, 32'hCAFE_0002);
    @(posedge clk); #1;
    chk("hold_state", {30'h0, dbg_state}, {30'h0, ST_HOLD});
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_if_en", {31'h0, if_en}, 32'h0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_insn", if_insn, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h1);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_state", {30'h0, dbg_state}, {30'h0, ST_FETCH});
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 1, 32'h0000_0011);
    @(posedge clk); #1;
    chk("restart_en", {31'h0, if_en}, 32'h1);
    chk("restart_pc", if_pc, 32'h0);
    chk("restart_insn", if_insn, 32'h0000_0011);

    // random run against the reference model
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
            $urandom, $urandom_range(0, 2) != 0, $urandom);
      #1;
      chk("rnd_req", {31'h0, imem_req}, {31'h0, model_req()});
      chk("rnd_busy", {31'h0, busy}, {31'h0, model_req() & ~imem_rdy});
      if (model_req()) chk("rnd_addr", imem_addr, m_disc ? m_daddr : m_pc);
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_en", {31'h0, if_en}, {31'h0, m_en});
      if (m_en) begin
        chk("rnd_pc", if_pc, m_out_pc);
        chk("rnd_pc4", if_pc_plus4, m_out_pc + 32'd4);
      end
      if (m_insn_known) chk("rnd_insn", if_insn, m_out_insn);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
